// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix ROM reader slice.
//   - Geometry of the 32x32 matrix held in the row-major ROM image.
//   - Reader FSM state encoding.
//   - Tagged stream element {data, row, col, last} at the default geometry.
//   - mat_index(): linear element index, row*MAT_DIM + col.
package matrix_pkg;

    localparam int MAT_ROW_BITS   = 5;
    localparam int MAT_COL_BITS   = 5;
    localparam int MAT_DIM        = 32;
    localparam int MAT_ELEMS      = 1024;
    localparam int MAT_DATA_WIDTH = 8;

    localparam logic [1:0] RD_IDLE  = 2'd0;
    localparam logic [1:0] RD_RUN   = 2'd1;
    localparam logic [1:0] RD_DRAIN = 2'd2;

    typedef struct packed {
        logic [MAT_DATA_WIDTH-1:0] data;
        logic [MAT_ROW_BITS-1:0]   row;
        logic [MAT_COL_BITS-1:0]   col;
        logic                      last;
    } mat_elem_t;

    function automatic int unsigned mat_index(input int unsigned row, input int unsigned col);
        return row * MAT_DIM + col;
    endfunction

endpackage

// File: rtl/rom_resp_fifo.sv
// Two-entry synchronous FIFO that holds ROM responses together with their tags.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset, empties the FIFO and clears storage
//   push  : write wdata this cycle; accepted when not full or when popping in the same cycle
//   wdata : tagged element to store
//   pop   : remove the head entry; ignored when empty
//   rdata : head entry, meaningful only while count != 0
//   count : current occupancy, 0..2
module rom_resp_fifo #(
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       cnt;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (cnt != 2'd0);
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push && ((cnt != 2'd2) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign count = cnt;

endmodule

// File: rtl/matrix_rom_reader.sv
// Matrix ROM reader: walks all elements of a 32x32 row-major ROM image in
// row-major or column-major order, hides the ROM's 1-cycle read latency and
// presents each element as a valid/ready stream beat tagged with row/col/last.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start; counters hold, nothing issued
//   RUN   | issuing ROM addresses whenever the response path has room
//   DRAIN | final address issued; waiting for the last beat to be accepted
//
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset; aborts any traversal
//   start     : begin a traversal (only honoured in IDLE, not in the done cycle)
//   col_major : traversal order, latched with start (0 row-major, 1 column-major)
//   busy      : high from accepted start through the done pulse
//   done      : one-cycle pulse after the last beat is accepted
//   rom_addr  : {row, col} address to the ROM
//   rom_q     : ROM data, one cycle after the address
//   m_valid / m_ready / m_data / m_row / m_col / m_last : element stream
module matrix_rom_reader
    import matrix_pkg::*;
#(
    parameter int DATA_WIDTH = MAT_DATA_WIDTH,
    parameter int ROW_BITS   = MAT_ROW_BITS,
    parameter int COL_BITS   = MAT_COL_BITS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         col_major,
    output logic                         busy,
    output logic                         done,
    output logic [ROW_BITS+COL_BITS-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0]        rom_q,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DATA_WIDTH-1:0]        m_data,
    output logic [ROW_BITS-1:0]          m_row,
    output logic [COL_BITS-1:0]          m_col,
    output logic                         m_last
);

    localparam int EW = DATA_WIDTH + ROW_BITS + COL_BITS + 1;

    logic [1:0]          state;
    logic [ROW_BITS-1:0] row_cnt;
    logic [COL_BITS-1:0] col_cnt;
    logic                col_major_q;
    logic                inflight;
    logic [ROW_BITS-1:0] tag_row;
    logic [COL_BITS-1:0] tag_col;
    logic                tag_last;
    logic                done_q;

    logic [1:0]          fifo_count;
    logic [EW-1:0]       fifo_head;
    logic [EW-1:0]       fifo_wdata;
    logic                fifo_valid;
    logic                pop;
    logic [2:0]          occ;
    logic                issue;
    logic                row_last;
    logic                col_last;
    logic                at_final;
    logic                start_acc;
    logic                head_last;

    assign fifo_valid = (fifo_count != 2'd0);
    assign pop        = fifo_valid && m_ready;
    assign head_last  = fifo_head[0];

    // Occupancy the response path will have after this edge if nothing new is
    // issued. Keeping it below 2 guarantees a slot for every ROM response.
    assign occ   = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    assign issue = (state == RD_RUN) && (occ < 3'd2);

    assign row_last  = &row_cnt;
    assign col_last  = &col_cnt;
    assign at_final  = row_last && col_last;
    // The done cycle is already IDLE, but a start there must not be taken.
    assign start_acc = (state == RD_IDLE) && start && !done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RD_IDLE;
            row_cnt     <= '0;
            col_cnt     <= '0;
            col_major_q <= 1'b0;
            inflight    <= 1'b0;
            tag_row     <= '0;
            tag_col     <= '0;
            tag_last    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            inflight <= issue;
            if (issue) begin
                tag_row  <= row_cnt;
                tag_col  <= col_cnt;
                tag_last <= at_final;
            end
            case (state)
                RD_IDLE: begin
                    if (start_acc) begin
                        state       <= RD_RUN;
                        row_cnt     <= '0;
                        col_cnt     <= '0;
                        col_major_q <= col_major;
                    end
                end
                RD_RUN: begin
                    if (issue) begin
                        if (at_final) begin
                            // Counters stay on the final address; no wrap.
                            state <= RD_DRAIN;
                        end else if (col_major_q) begin
                            if (row_last) begin
                                row_cnt <= '0;
                                col_cnt <= col_cnt + 1'b1;
                            end else begin
                                row_cnt <= row_cnt + 1'b1;
                            end
                        end else begin
                            if (col_last) begin
                                col_cnt <= '0;
                                row_cnt <= row_cnt + 1'b1;
                            end else begin
                                col_cnt <= col_cnt + 1'b1;
                            end
                        end
                    end
                end
                RD_DRAIN: begin
                    if (pop && head_last) begin
                        state  <= RD_IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= RD_IDLE;
            endcase
        end
    end

    // The response arriving now belongs to the issue of the previous cycle.
    assign fifo_wdata = {rom_q, tag_row, tag_col, tag_last};

    rom_resp_fifo #(
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_head),
        .count (fifo_count)
    );

    assign rom_addr = {row_cnt, col_cnt};
    assign busy     = (state != RD_IDLE) || done_q;
    assign done     = done_q;

    // Payload is forced to zero when no beat is presented so stale FIFO
    // contents never show on the stream.
    assign m_valid = fifo_valid;
    assign m_data  = fifo_valid ? fifo_head[EW-1 -: DATA_WIDTH]                : '0;
    assign m_row   = fifo_valid ? fifo_head[COL_BITS+1 +: ROW_BITS]           : '0;
    assign m_col   = fifo_valid ? fifo_head[1 +: COL_BITS]                    : '0;
    assign m_last  = fifo_valid && head_last;

endmodule

// File: tb/tb_matrix_rom_reader.sv
module tb_matrix_rom_reader;
    import matrix_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       col_major;
    logic       busy;
    logic       done;
    logic [9:0] rom_addr;
    logic [7:0] rom_q = 8'd0;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic [7:0] m_data;
    logic [4:0] m_row;
    logic [4:0] m_col;
    logic       m_last;

    int checks   = 0;
    int failures = 0;
    int mode     = 0;      // m_ready driver: 0 always high, 1 random 30%, 2 held low
    int hs_total = 0;

    mat_elem_t exp_q[$];

    matrix_rom_reader #(
        .DATA_WIDTH (8),
        .ROW_BITS   (5),
        .COL_BITS   (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .col_major (col_major),
        .busy      (busy),
        .done      (done),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_row     (m_row),
        .m_col     (m_col),
        .m_last    (m_last)
    );

    always #5 clk = ~clk;

    // ROM model: one-cycle latency, image value (row*32+col) mod 256.
    always @(posedge clk) begin
        rom_q <= 8'(mat_index(32'(rom_addr[9:5]), 32'(rom_addr[4:0])) % 256);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected beats for one traversal, straight from the ordering rules.
    task automatic push_traversal(input bit cm);
        mat_elem_t e;
        for (int k = 0; k < MAT_ELEMS; k++) begin
            if (cm) begin
                e.col = 5'(k / MAT_DIM);
                e.row = 5'(k % MAT_DIM);
            end else begin
                e.row = 5'(k / MAT_DIM);
                e.col = 5'(k % MAT_DIM);
            end
            e.data = 8'(mat_index(32'(e.row), 32'(e.col)) % 256);
            e.last = (k == MAT_ELEMS - 1);
            exp_q.push_back(e);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ($urandom_range(0, 99) < 30);
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Monitor / scoreboard.
    initial begin
        mat_elem_t cur;
        mat_elem_t prev_elem;
        mat_elem_t e;
        bit prev_stall = 0;
        bit exp_done   = 0;
        bit after_done = 0;
        prev_elem = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
                exp_done   = 0;
                after_done = 0;
            end else begin
                cur.data = m_data;
                cur.row  = m_row;
                cur.col  = m_col;
                cur.last = m_last;
                if (exp_done) begin
                    chk("done_pulse", 32'(done), 32'd1);
                    chk("busy_in_done", 32'(busy), 32'd1);
                end else if (done) begin
                    chk("spurious_done", 32'(done), 32'd0);
                end
                if (after_done) chk("busy_after_done", 32'(busy), 32'd0);
                after_done = exp_done;
                exp_done   = m_valid && m_ready && m_last;
                if (prev_stall) begin
                    chk("valid_hold", 32'(m_valid), 32'd1);
                    if (m_valid) chk("stall_stable", 32'(cur), 32'(prev_elem));
                end
                if (m_valid && m_ready) begin
                    hs_total++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat actual=%0h expected=none at %0t", cur, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", 32'(cur), 32'(e));
                    end
                end
                prev_stall = m_valid && !m_ready;
                prev_elem  = cur;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},     32'(busy),     32'd0);
        chk({tag, "_done"},     32'(done),     32'd0);
        chk({tag, "_m_valid"},  32'(m_valid),  32'd0);
        chk({tag, "_m_last"},   32'(m_last),   32'd0);
        chk({tag, "_m_data"},   32'(m_data),   32'd0);
        chk({tag, "_m_row"},    32'(m_row),    32'd0);
        chk({tag, "_m_col"},    32'(m_col),    32'd0);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    endtask

    // Returns just after the start edge; start stays high when hold is set.
    task automatic start_trav(input bit cm, input bit hold);
        @(posedge clk);
        #1;
        start     = 1'b1;
        col_major = cm;
        push_traversal(cm);
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    // Counts negedges after the start edge; returns at the done cycle.
    task automatic wait_done(input int budget, output int first_valid, output int done_cyc);
        int cyc = 0;
        first_valid = -1;
        done_cyc    = -1;
        forever begin
            @(negedge clk);
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (cyc >= budget) begin
                checks++;
                failures++;
                $display("FAIL wait_done timeout actual=%0d cycles expected=done", cyc);
                break;
            end
            cyc++;
        end
    endtask

    initial begin
        int fv;
        int dc;
        int base;
        int guard;
        rst       = 1'b1;
        start     = 1'b0;
        col_major = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Row-major, always ready: latency and throughput.
        mode = 0;
        start_trav(1'b0, 1'b0);
        wait_done(3000, fv, dc);
        chk("first_valid_cycle", 32'(fv), 32'd2);
        chk("done_cycle", 32'(dc), 32'd1026);
        repeat (3) @(posedge clk);

        // Column-major.
        start_trav(1'b1, 1'b0);
        wait_done(3000, fv, dc);
        chk("cm_done_cycle", 32'(dc), 32'd1026);
        repeat (3) @(posedge clk);

        // Backpressure: random 30% ready plus a 50-cycle stall burst.
        mode = 1;
        start_trav(1'(($urandom_range(0, 1))), 1'b0);
        repeat (300) @(posedge clk);
        mode = 2;
        repeat (50) @(posedge clk);
        mode = 1;
        wait_done(20000, fv, dc);
        mode = 0;
        repeat (3) @(posedge clk);

        // Start held through the whole run and the done cycle, then one more cycle.
        start_trav(1'b0, 1'b1);
        wait_done(3000, fv, dc);
        @(posedge clk);
        #1;
        push_traversal(1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(3000, fv, dc);
        chk("restart_done_cycle", 32'(dc), 32'd1026);
        repeat (3) @(posedge clk);

        // Async reset around beat 500 with the stream stalled.
        base = hs_total;
        start_trav(1'b1, 1'b0);
        guard = 0;
        while ((hs_total - base) < 500 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        chk("reached_beat_500", 32'((hs_total - base) >= 500), 32'd1);
        mode = 2;
        repeat (3) @(negedge clk);
        chk("stalled_before_reset", 32'(m_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        mode = 0;
        start_trav(1'b0, 1'b0);
        wait_done(3000, fv, dc);
        chk("post_reset_first_valid", 32'(fv), 32'd2);
        chk("post_reset_done_cycle", 32'(dc), 32'd1026);
        repeat (5) @(posedge clk);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matrix_rom_reader.md
Name: matrix_rom_reader

Overview:
- Initiator for the synchronous matrix ROM: sequences ROM addresses over a 32x32 matrix and absorbs the ROM's fixed 1-cycle read latency.
- Emits elements as a valid/ready stream tagged with row/column and last flag.
- Supports row-major or column-major traversal, so downstream matrix units (multiply, transpose) get elements in the order they need without a second ROM image.

Parameters:
- DATA_WIDTH, 8, element width; must match ROM DATA_WIDTH.
- ROW_BITS, 5, log2 of rows (32 rows).
- COL_BITS, 5, log2 of columns (32 columns); ROM ADDR_WIDTH = ROW_BITS+COL_BITS.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin traversal; sampled only in IDLE.
- col_major  in  1  traversal order (0 row-major, 1 column-major); latched when start is accepted.
- busy  out  1  high from accepted start until the done pulse, inclusive.
- done  out  1  one-cycle pulse after the last element handshake.
- rom_addr  out  ROW_BITS+COL_BITS  ROM address = {row,col}; ROM image is row-major.
- rom_q  in  DATA_WIDTH  ROM data, valid the cycle after the address is sampled.
- m_valid  out  1  stream element valid.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_WIDTH  element value.
- m_row  out  ROW_BITS  element row index.
- m_col  out  COL_BITS  element column index.
- m_last  out  1  high with the final (1024th) element.

Behaviour:
- Reset (async, any time): state IDLE, counters 0, inflight 0, FIFO empty.
  - Outputs: busy=0, done=0, m_valid=0, m_last=0, m_data/m_row/m_col=0, rom_addr=0.
  - Mid-traversal reset discards all in-flight and buffered data; the traversal is not resumed.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start=1: latch col_major, clear row/col counters.
  - RUN -> DRAIN the cycle the final address (row=31, col=31) is issued.
  - DRAIN -> IDLE on the handshake (m_valid & m_ready) of the m_last element; done pulses the following cycle. busy is high in RUN and DRAIN and during the done cycle.
  - start is ignored outside IDLE, including the done cycle.
- rom_addr is combinational {row_cnt,col_cnt}. The ROM samples every edge; an "issue" is an edge on which an internal issue strobe is high.
- Issue rule: issue iff state==RUN and (fifo_count + inflight - pop) < 2, where pop = m_valid & m_ready. Counters advance only on issue; when stalled, rom_addr holds its value.
- inflight register = issue of the previous cycle. When inflight=1, rom_q plus the row/col/last tag captured at issue is pushed into a 2-entry FIFO. The FIFO never overflows under the issue rule.
- Traversal order:
  - Row-major: col increments; on col wrap 31->0, row increments.
  - Column-major: row increments; on row wrap 31->0, col increments.
  - Exactly 1024 issues per traversal; no wrap beyond the last element.
- Stream rules:
  - m_* is driven by the FIFO head; m_valid = FIFO not empty.
  - m_data/m_row/m_col/m_last stay stable while m_valid & !m_ready.
  - m_valid never drops without a handshake.
  - Simultaneous push and pop is legal at any occupancy 0..2.
- Latency: start sampled at edge 0 -> address 0 issued at edge 1 -> m_valid high after edge 2. With m_ready held high, throughput is 1 element/cycle; the last element is presented 1025 cycles after the start edge, and done pulses the cycle after its handshake.
- Width rule: element index = row*32+col, unsigned, no arithmetic beyond the counters.

Decomposition:
- Package matrix_pkg:
  - MAT_ROW_BITS=5, MAT_COL_BITS=5, MAT_DIM=32, MAT_ELEMS=1024.
  - Reader state encoding (IDLE/RUN/DRAIN).
  - Tagged-element typedef {data, row, col, last}.
- Sub-module: rom_resp_fifo, a 2-entry synchronous FIFO with count output, async active-high reset, holding the tagged element. FSM, counters, and the issue logic stay in matrix_rom_reader.

Test Plan:
- Setup for all scenarios: bench ROM model with 1-cycle latency; image value = (row*32+col) mod 256.
- Row-major, m_ready=1: pulse start -> m_valid rises 2 cycles after the start edge; 1024 beats with data k mod 256 and (row,col)=(k/32,k%32); m_last only on beat 1023 (data 255, row 31, col 31); done pulses once the following cycle; busy then drops.
- Column-major: start with col_major=1 -> beat 0 = (0,0) data 0; beat 1 = (1,0) data 32; beat 32 = (0,1) data 1; last = (31,31) data 255.
- Backpressure: m_ready random 30% duty, plus a 50-cycle hold-low burst -> no lost, duplicated, or reordered beats; outputs stable while stalled; ≤2 issues outstanding beyond accepted beats.
- Start abuse: start held high for the whole run and re-pulsed during DRAIN -> exactly one traversal; a new start the cycle after done is ignored; a start one cycle later begins a second identical traversal.
- Async reset at beat 500 while m_ready is low -> all outputs 0 immediately; afterwards start produces a fresh traversal from (0,0) with no stale beats.
